// File: rtl/led_blink_monitor_if.sv
// Status and control bundle between a blink monitor and its host.
// The host drives led_in/clear; the monitor returns measured status.
interface led_blink_monitor_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BLINK_W = 16
);
    logic               led_in;
    logic               clear;
    logic [BLINK_W-1:0] blink_count;
    logic [CNT_W-1:0]   last_period;
    logic               period_valid;
    logic               locked;
    logic               error;
    logic               timeout;

    modport master (
        output led_in,
        output clear,
        input  blink_count,
        input  last_period,
        input  period_valid,
        input  locked,
        input  error,
        input  timeout
    );

    modport slave (
        input  led_in,
        input  clear,
        output blink_count,
        output last_period,
        output period_valid,
        output locked,
        output error,
        output timeout
    );
endinterface

// File: rtl/led_blink_monitor.sv
// Measures half-periods of an asynchronous blink input, counts rising edges,
// and reports lock, sticky error and stall timeout against an expected period.
module led_blink_monitor #(
    parameter int unsigned PERIOD     = 4975,
    parameter int unsigned TOLERANCE  = 2,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned BLINK_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    led_blink_monitor_if.slave    bus
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   PERIOD_C    = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0]   TOL_C       = CNT_W'(TOLERANCE);
    localparam logic [CNT_W-1:0]   TIMEOUT_C   = CNT_W'(2 * PERIOD);
    localparam logic [GOOD_W-1:0]  GOOD_MAX    = GOOD_W'(LOCK_COUNT);
    localparam logic [BLINK_W-1:0] BLINK_MAX   = {BLINK_W{1'b1}};

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MEASURE = 1'b1;

    logic               sync1_q;
    logic               sync2_q;
    logic               delayed_q;
    logic               toggle_c;
    logic               rise_c;

    logic [0:0]         state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [GOOD_W-1:0]  good_q,   good_d;
    logic [BLINK_W-1:0] blink_q,  blink_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               valid_q,  valid_d;
    logic               locked_q, locked_d;
    logic               error_q,  error_d;
    logic               timeout_q, timeout_d;

    logic [CNT_W-1:0]   elapsed;
    logic [CNT_W-1:0]   deviation;
    logic               in_tol;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            delayed_q <= 1'b0;
        end else begin
            sync1_q   <= bus.led_in;
            sync2_q   <= sync1_q;
            delayed_q <= sync2_q;
        end
    end

    assign toggle_c = sync2_q ^ delayed_q;
    assign rise_c   = sync2_q & ~delayed_q;

    // cnt_q holds clocks since the last toggle minus one, so elapsed is the interval
    always_comb begin
        elapsed   = cnt_q + CNT_W'(1);
        deviation = (elapsed >= PERIOD_C) ? (elapsed - PERIOD_C) : (PERIOD_C - elapsed);
        in_tol    = (deviation <= TOL_C);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        blink_d   = blink_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        error_d   = error_q;
        timeout_d = timeout_q;

        if (bus.clear) begin
            state_d   = IDLE;
            cnt_d     = '0;
            good_d    = '0;
            blink_d   = '0;
            period_d  = '0;
            locked_d  = 1'b0;
            error_d   = 1'b0;
            timeout_d = 1'b0;
        end else begin
            if (rise_c && (blink_q != BLINK_MAX)) begin
                blink_d = blink_q + BLINK_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (toggle_c) begin
                        state_d   = MEASURE;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                    end
                end
                MEASURE: begin
                    if (toggle_c) begin
                        cnt_d    = '0;
                        period_d = elapsed;
                        valid_d  = 1'b1;
                        if (in_tol) begin
                            good_d   = (good_q < GOOD_MAX) ? (good_q + GOOD_W'(1)) : good_q;
                            locked_d = (good_d == GOOD_MAX);
                        end else begin
                            good_d   = '0;
                            locked_d = 1'b0;
                            error_d  = 1'b1;
                        end
                    end else if (elapsed == TIMEOUT_C) begin
                        // Stall: drop the reference; the next toggle re-arms
                        state_d   = IDLE;
                        cnt_d     = '0;
                        good_d    = '0;
                        locked_d  = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = elapsed;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            good_q    <= '0;
            blink_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            blink_q   <= blink_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.blink_count  = blink_q;
    assign bus.last_period  = period_q;
    assign bus.period_valid = valid_q;
    assign bus.locked       = locked_q;
    assign bus.error        = error_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_led_blink_monitor.sv
// Directed bench for led_blink_monitor with PERIOD=100; a second instance
// with a 4-bit blink counter covers saturation.
module tb_led_blink_monitor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    led_blink_monitor_if #(.CNT_W(32), .BLINK_W(16)) bus_a ();
    led_blink_monitor_if #(.CNT_W(32), .BLINK_W(4))  bus_b ();

    led_blink_monitor #(
        .PERIOD(100), .TOLERANCE(2), .LOCK_COUNT(4), .CNT_W(32), .BLINK_W(16)
    ) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    led_blink_monitor #(
        .PERIOD(100), .TOLERANCE(2), .LOCK_COUNT(4), .CNT_W(32), .BLINK_W(4)
    ) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int lock_at = -1;
    logic lock_seen = 1'b0;
    int pv_base;

    // Counts period_valid pulses and records which measurement first locked
    always @(posedge clk) begin
        if (bus_a.period_valid) pv_cnt <= pv_cnt + 1;
        if (bus_a.locked && !lock_seen) begin
            lock_seen <= 1'b1;
            lock_at   <= pv_cnt + (bus_a.period_valid ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_toggle(input int n);
        repeat (n) @(negedge clk);
        bus_a.led_in = ~bus_a.led_in;
    endtask

    task automatic wait_toggle_b(input int n);
        repeat (n) @(negedge clk);
        bus_b.led_in = ~bus_b.led_in;
    endtask

    initial begin
        bus_a.led_in = 1'b0;
        bus_a.clear  = 1'b0;
        bus_b.led_in = 1'b0;
        bus_b.clear  = 1'b0;

        // Reset held while led_in toggles
        for (int i = 0; i < 6; i++) wait_toggle(3);
        check("rst_blink",   32'(bus_a.blink_count), 0);
        check("rst_period",  bus_a.last_period, 0);
        check("rst_valid",   32'(bus_a.period_valid), 0);
        check("rst_locked",  32'(bus_a.locked), 0);
        check("rst_error",   32'(bus_a.error), 0);
        check("rst_timeout", 32'(bus_a.timeout), 0);
        bus_a.led_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Ideal blinker: first toggle is reference only
        wait_toggle(0);
        repeat (5) @(negedge clk);
        check("first_no_valid", 32'(pv_cnt), 0);
        wait_toggle(95);
        for (int i = 0; i < 18; i++) wait_toggle(100);
        repeat (5) @(negedge clk);
        check("ideal_pv_count", 32'(pv_cnt), 19);
        check("ideal_period",   bus_a.last_period, 100);
        check("ideal_blinks",   32'(bus_a.blink_count), 10);
        check("ideal_error",    32'(bus_a.error), 0);
        check("ideal_locked",   32'(bus_a.locked), 1);
        check("lock_at_4th",    32'(lock_at), 4);

        // Jitter at the tolerance edges keeps lock
        wait_toggle(93);
        wait_toggle(102);
        repeat (5) @(negedge clk);
        check("jit102_period", bus_a.last_period, 102);
        check("jit102_locked", 32'(bus_a.locked), 1);
        check("jit102_error",  32'(bus_a.error), 0);
        wait_toggle(98);
        repeat (5) @(negedge clk);
        check("jit103_period", bus_a.last_period, 103);
        check("jit103_locked", 32'(bus_a.locked), 0);
        check("jit103_error",  32'(bus_a.error), 1);
        wait_toggle(95);
        for (int i = 0; i < 3; i++) wait_toggle(100);
        repeat (5) @(negedge clk);
        check("relock_locked", 32'(bus_a.locked), 1);
        check("relock_error",  32'(bus_a.error), 1);

        bus_a.clear = 1'b1;
        @(negedge clk);
        bus_a.clear = 1'b0;
        repeat (4) @(negedge clk);
        check("clr_error",  32'(bus_a.error), 0);
        check("clr_blink",  32'(bus_a.blink_count), 0);
        check("clr_period", bus_a.last_period, 0);
        check("clr_locked", 32'(bus_a.locked), 0);

        // Stall after lock
        wait_toggle(0);
        for (int i = 0; i < 4; i++) wait_toggle(100);
        repeat (202) @(negedge clk);
        check("stall199_timeout", 32'(bus_a.timeout), 0);
        check("stall199_locked",  32'(bus_a.locked), 1);
        @(negedge clk);
        check("stall200_timeout", 32'(bus_a.timeout), 1);
        check("stall200_locked",  32'(bus_a.locked), 0);
        pv_base = pv_cnt;
        wait_toggle(10);
        repeat (5) @(negedge clk);
        check("rearm_timeout",  32'(bus_a.timeout), 0);
        check("rearm_no_valid", 32'(pv_cnt - pv_base), 0);
        wait_toggle(95);
        repeat (5) @(negedge clk);
        check("rearm_valid",  32'(pv_cnt - pv_base), 1);
        check("rearm_period", bus_a.last_period, 100);

        // Edge lands exactly on the timeout count
        wait_toggle(195);
        repeat (5) @(negedge clk);
        check("edge200_period",  bus_a.last_period, 200);
        check("edge200_error",   32'(bus_a.error), 1);
        check("edge200_timeout", 32'(bus_a.timeout), 0);

        // clear coincident with a detected rising edge
        if (bus_a.led_in) wait_toggle(50);
        repeat (10) @(negedge clk);
        pv_base = pv_cnt;
        wait_toggle(0);
        repeat (2) @(negedge clk);
        bus_a.clear = 1'b1;
        @(negedge clk);
        bus_a.clear = 1'b0;
        repeat (5) @(negedge clk);
        check("clr_edge_blink", 32'(bus_a.blink_count), 0);
        check("clr_edge_error", 32'(bus_a.error), 0);
        wait_toggle(50);
        repeat (5) @(negedge clk);
        check("clr_edge_idle", 32'(pv_cnt - pv_base), 0);
        wait_toggle(50);
        repeat (5) @(negedge clk);
        check("post_clr_period", bus_a.last_period, 55);
        check("post_clr_blink",  32'(bus_a.blink_count), 1);

        // Saturating blink counter on the 4-bit instance
        for (int i = 0; i < 28; i++) wait_toggle_b(3);
        repeat (5) @(negedge clk);
        check("sat_14", 32'(bus_b.blink_count), 14);
        for (int i = 0; i < 12; i++) wait_toggle_b(3);
        repeat (5) @(negedge clk);
        check("sat_15", 32'(bus_b.blink_count), 15);

        // Asynchronous reset mid-interval, checked before the next clock edge
        repeat (20) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_blink",   32'(bus_a.blink_count), 0);
        check("async_period",  bus_a.last_period, 0);
        check("async_valid",   32'(bus_a.period_valid), 0);
        check("async_locked",  32'(bus_a.locked), 0);
        check("async_error",   32'(bus_a.error), 0);
        check("async_timeout", 32'(bus_a.timeout), 0);
        check("async_blink_b", 32'(bus_b.blink_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
